fcs_check: RTL and testbench

FCS_CHECK -- requirements
Module: fcs_check

---
 rtl/fcs_check.sv | 160 ++++++++++++++++
 tb/tb_fcs_check.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fcs_check.sv
// -----------------------------------------------------------------------------
// fcs_check -- serial CRC-16 frame check sequence verifier.
//
// A frame arrives one bit per clock, MSB first, while en is high: payload bits
// followed by a 16-bit FCS. The last 16 bits are held back in a delay register
// so that only payload bits reach the CRC (poly 0x1021, init 0, no reflection,
// no final XOR). When en falls, the received FCS, the computed CRC and the
// length/match verdicts are registered and done is raised until the next frame
// starts.
//
// Ports
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous reset, active low
//   en        in   1   frame valid, high for every bit of a frame
//   data      in   1   serial frame bit
//   done      out  1   result of the last frame is valid
//   crc_ok    out  1   last frame had legal length and matching FCS
//   LenError  out  1   last frame payload length outside [MIN_LEN, MAX_LEN]
//   FCS_rx    out  16  last 16 bits received (right-aligned for short frames)
//   FCS_calc  out  16  CRC over the payload bits only
// -----------------------------------------------------------------------------
module fcs_check #(
  parameter int MIN_LEN = 8,
  parameter int MAX_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        data,
  output logic        done,
  output logic        crc_ok,
  output logic        LenError,
  output logic [15:0] FCS_rx,
  output logic [15:0] FCS_calc
);

  localparam logic [15:0] POLY    = 16'h1021;
  // Total-bit bounds: payload limits plus the 16-bit FCS field.
  localparam logic [15:0] MIN_T   = 16'(MIN_LEN + 16);
  localparam logic [15:0] MAX_T   = 16'(MAX_LEN + 16);
  // Counter stops one above the largest legal total so it can never wrap
  // back into the legal range.
  localparam logic [15:0] CNT_SAT = 16'(MAX_LEN + 17);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  // One MSB-first CRC-16 step for a single input bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] dly_q, dly_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic        len_q, len_d;
  logic [15:0] fcs_rx_q, fcs_rx_d;
  logic [15:0] fcs_calc_q, fcs_calc_d;
  logic        len_err_s;

  // Length verdict for the frame currently being received (T = cnt_q).
  assign len_err_s = (cnt_q < MIN_T) || (cnt_q > MAX_T);

  // Next-state and datapath logic; every register holds by default.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    dly_d      = dly_q;
    done_d     = done_q;
    ok_d       = ok_q;
    len_d      = len_q;
    fcs_rx_d   = fcs_rx_q;
    fcs_calc_d = fcs_calc_q;
    case (state_q)
      IDLE, DONE: begin
        if (en) begin
          // First bit of a new frame: it is bit 0, so one bit is now held.
          cnt_d   = 16'd1;
          crc_d   = 16'h0000;
          dly_d   = {15'd0, data};
          done_d  = 1'b0;
          ok_d    = 1'b0;
          len_d   = 1'b0;
          state_d = RECV;
        end else begin
          state_d = state_q;
        end
      end
      RECV: begin
        if (en) begin
          dly_d = {dly_q[14:0], data};
          // The bit leaving the delay line is payload only once the line
          // is already full; earlier bits may still turn out to be FCS.
          if (cnt_q >= 16'd16) begin
            crc_d = crc16_step(crc_q, dly_q[15]);
          end else begin
            crc_d = crc_q;
          end
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 16'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          fcs_rx_d   = dly_q;
          fcs_calc_d = crc_q;
          len_d      = len_err_s;
          ok_d       = ~len_err_s & (crc_q == dly_q);
          done_d     = 1'b1;
          state_d    = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      crc_q      <= 16'h0000;
      dly_q      <= 16'h0000;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      len_q      <= 1'b0;
      fcs_rx_q   <= 16'h0000;
      fcs_calc_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      dly_q      <= dly_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      len_q      <= len_d;
      fcs_rx_q   <= fcs_rx_d;
      fcs_calc_q <= fcs_calc_d;
    end
  end

  assign done     = done_q;
  assign crc_ok   = ok_q;
  assign LenError = len_q;
  assign FCS_rx   = fcs_rx_q;
  assign FCS_calc = fcs_calc_q;

endmodule

// File: tb/tb_fcs_check.sv
// -----------------------------------------------------------------------------
// tb_fcs_check -- scoreboard bench for fcs_check.
// The driver builds each frame as a bit queue, predicts the result with a
// polynomial long-division model and pushes it; a monitor pops and compares on
// every rising edge of done.
// -----------------------------------------------------------------------------
module tb_fcs_check;

  localparam int MIN_LEN = 8;
  localparam int MAX_LEN = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        data;
  logic        done;
  logic        crc_ok;
  logic        LenError;
  logic [15:0] FCS_rx;
  logic [15:0] FCS_calc;

  fcs_check #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .data     (data),
    .done     (done),
    .crc_ok   (crc_ok),
    .LenError (LenError),
    .FCS_rx   (FCS_rx),
    .FCS_calc (FCS_calc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rx;
    logic [15:0] calc;
    logic        len;
    logic        ok;
    int          tot;
  } exp_t;

  exp_t sb[$];
  bit   frm[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Remainder of M(x)*x^16 divided by x^16+x^12+x^5+1, M = first n frame bits.
  function automatic logic [15:0] model_crc(input int n);
    bit          a[];
    logic [16:0] g;
    logic [15:0] r;
    g = 17'h11021;
    a = new[n + 16];
    for (int i = 0; i < n + 16; i++) a[i] = (i < n) ? frm[i] : 1'b0;
    for (int i = 0; i < n; i++) begin
      if (a[i]) begin
        for (int j = 0; j <= 16; j++) a[i + j] = a[i + j] ^ g[16 - j];
      end
    end
    r = 16'h0000;
    for (int k = 0; k < 16; k++) r[15 - k] = a[n + k];
    return r;
  endfunction

  function automatic void push_expect();
    exp_t e;
    int   t;
    int   s;
    t = frm.size();
    e.tot  = t;
    e.calc = (t > 16) ? model_crc(t - 16) : 16'h0000;
    e.rx   = 16'h0000;
    s = (t > 16) ? t - 16 : 0;
    for (int i = s; i < t; i++) e.rx = {e.rx[14:0], frm[i]};
    e.len = (t < MIN_LEN + 16) || (t > MAX_LEN + 16);
    e.ok  = !e.len && (e.calc == e.rx);
    sb.push_back(e);
  endfunction

  function automatic void add_rand(input int n);
    for (int i = 0; i < n; i++) frm.push_back(1'($urandom_range(0, 1)));
  endfunction

  function automatic void add_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) frm.push_back(w[i]);
  endfunction

  function automatic void add_ascii(input string s);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      for (int b = 7; b >= 0; b--) frm.push_back(c[b]);
    end
  endfunction

  // Random payload of p bits followed by its correct FCS.
  function automatic void add_good(input int p);
    logic [15:0] c;
    add_rand(p);
    c = model_crc(frm.size());
    add_word(c);
  endfunction

  // Drive frm, then one en=0 edge; returns 1 time unit after that edge.
  task automatic send_frame(input string tag);
    push_expect();
    for (int i = 0; i < frm.size(); i++) begin
      en   = 1'b1;
      data = frm[i];
      @(posedge clk); #1;
      if (i == 0) chk({tag, "_done_drop"}, 32'(done), 32'd0);
    end
    en   = 1'b0;
    data = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_latency"}, 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every rising edge of done must match the oldest prediction.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        e = sb.pop_front();
        chk($sformatf("T%0d_FCS_rx", e.tot),   32'(FCS_rx),   32'(e.rx));
        chk($sformatf("T%0d_FCS_calc", e.tot), 32'(FCS_calc), 32'(e.calc));
        chk($sformatf("T%0d_LenError", e.tot), 32'(LenError), 32'(e.len));
        chk($sformatf("T%0d_crc_ok", e.tot),   32'(crc_ok),   32'(e.ok));
      end
    end
    prev_done = done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    rst  = 1'b0;
    en   = 1'b0;
    data = 1'b0;
    idle(3);
    chk("reset_done",     32'(done),     32'd0);
    chk("reset_crc_ok",   32'(crc_ok),   32'd0);
    chk("reset_LenError", 32'(LenError), 32'd0);
    chk("reset_FCS_rx",   32'(FCS_rx),   32'd0);
    chk("reset_FCS_calc", 32'(FCS_calc), 32'd0);
    rst = 1'b1;
    idle(2);

    // Reference frame "123456789" + 0x31C3.
    frm.delete(); add_ascii("123456789"); add_word(16'h31C3);
    send_frame("good");
    idle(2);

    // Payload bit 10 inverted.
    frm.delete(); add_ascii("123456789"); add_word(16'h31C3);
    frm[10] = ~frm[10];
    send_frame("biterr");
    idle(2);

    // Short frames and exact boundaries around the 16-bit delay line.
    frm.delete(); add_rand(20);  send_frame("short20"); idle(1);
    frm.delete(); add_rand(10);  send_frame("short10"); idle(1);
    frm.delete(); add_rand(1);   send_frame("short1");  idle(1);
    frm.delete(); add_rand(16);  send_frame("t16");     idle(1);
    frm.delete(); add_good(7);   send_frame("t23");     idle(1);
    frm.delete(); add_good(8);   send_frame("t24");     idle(1);

    // Long frames: one past the limit, at the limit, and well past saturation.
    frm.delete(); add_good(1025); send_frame("long1041"); idle(1);
    frm.delete(); add_good(1024); send_frame("long1040"); idle(1);
    frm.delete(); add_good(1200); send_frame("long1216"); idle(1);

    // Back-to-back with a single idle edge; second frame carries an error.
    frm.delete(); add_ascii("123456789"); add_word(16'h31C3);
    send_frame("b2b_a");
    frm.delete(); add_ascii("123456789"); add_word(16'h31C2);
    send_frame("b2b_b");
    chk("b2b_final_crc_ok", 32'(crc_ok), 32'd0);
    idle(2);

    // Reset after 40 bits; the next edge after release starts a frame.
    frm.delete(); add_rand(40);
    for (int i = 0; i < 40; i++) begin
      en   = 1'b1;
      data = frm[i];
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_done",     32'(done),     32'd0);
    chk("abort_crc_ok",   32'(crc_ok),   32'd0);
    chk("abort_LenError", 32'(LenError), 32'd0);
    chk("abort_FCS_rx",   32'(FCS_rx),   32'd0);
    chk("abort_FCS_calc", 32'(FCS_calc), 32'd0);
    rst = 1'b1;
    frm.delete(); add_ascii("123456789"); add_word(16'h31C3);
    send_frame("after_abort");
    idle(2);

    // Randomized frames: mixed lengths, half with a correct FCS.
    for (int r = 0; r < 24; r++) begin
      frm.delete();
      if (r % 8 == 7) t = $urandom_range(1030, 1050);
      else            t = $urandom_range(1, 72);
      if (t > 16 && $urandom_range(0, 1) == 1) add_good(t - 16);
      else                                     add_rand(t);
      send_frame($sformatf("rnd%0d", r));
      idle($urandom_range(0, 3));
    end

    idle(5);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
